branch_resolve_ctrl: RTL and testbench

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

---
 rtl/branch_resolve_ctrl.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Resolves conditional branches in ID. When an older instruction in EX or
//   MEM still has to produce a branch source, it stalls for 1 or 2 cycles
//   before driving the compare unit. It also keeps saturating statistics
//   counters.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_valid              a branch-class instruction is present in ID
//   id_brop[5:0]          branch code (6 beq, 7 bne, 33 bgtz, 34 bgez,
//                         35 bltz, 36 blez)
//   id_rs, id_rt          source register indices
//   ex_regwrite, ex_memread, ex_rd   EX-stage writer
//   mem_memread, mem_rd              MEM-stage load
//   cmp_ctrl[5:0]         operation code for the compare unit (0 = idle)
//   cmp_zero .. cmp_lezero           compare-unit result flags
//   stall                 freeze PC and IF/ID, insert a bubble into EX
//   taken, flush_if       branch resolved taken this cycle / squash IF/ID
//   illegal               id_brop is not a branch code (IDLE only)
//   br_cnt, taken_cnt, stall_cnt     saturating statistics counters
//   dbg_state             current FSM state (0 IDLE, 1 STALL)
//
// Handshake: id_valid qualifies the ID-stage fields on each cycle. There is
// no ready. The producer holds the branch while stall=1. If it drops
// id_valid during a stall, the branch is abandoned.
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_brop,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  output logic [5:0]       cmp_ctrl,
  input  logic             cmp_zero,
  input  logic             cmp_gtzero,
  input  logic             cmp_gezero,
  input  logic             cmp_ltzero,
  input  logic             cmp_lezero,
  output logic             stall,
  output logic             taken,
  output logic             flush_if,
  output logic             illegal,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_nx;
  logic [1:0] wcnt, wcnt_nx;
  logic       legal, uses_rt, match_ex, match_mem, resolve, cond;
  logic [1:0] need;

  // Hazard detection. Register 0 is hard-wired, so it never creates a hazard.
  always_comb begin
    legal     = (id_brop == 6'd6)  || (id_brop == 6'd7)  || (id_brop == 6'd33) ||
                (id_brop == 6'd34) || (id_brop == 6'd35) || (id_brop == 6'd36);
    uses_rt   = (id_brop == 6'd6) || (id_brop == 6'd7);
    match_ex  = (ex_rd != 5'd0) &&
                ((ex_rd == id_rs) || (uses_rt && (ex_rd == id_rt)));
    match_mem = (mem_rd != 5'd0) &&
                ((mem_rd == id_rs) || (uses_rt && (mem_rd == id_rt)));
    // A load in EX needs two cycles. Any other in-flight producer needs one.
    if (ex_memread && match_ex)
      need = 2'd2;
    else if ((ex_regwrite && match_ex) || (mem_memread && match_mem))
      need = 2'd1;
    else
      need = 2'd0;
  end

  // Next state and control
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    stall    = 1'b0;
    resolve  = 1'b0;
    illegal  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (id_valid) begin
            if (!legal) begin
              illegal = 1'b1;
            end else if (need == 2'd0) begin
              resolve = 1'b1;
            end else begin
              stall    = 1'b1;
              state_nx = STALL;
              wcnt_nx  = need - 2'd1;
            end
          end
        end
        STALL: begin
          // EX/MEM hazards are not re-evaluated here. The wait length was
          // fixed when the stall began.
          if (!id_valid) begin
            state_nx = IDLE;
            wcnt_nx  = 2'd0;
          end else if (wcnt != 2'd0) begin
            stall   = 1'b1;
            wcnt_nx = wcnt - 2'd1;
          end else begin
            resolve  = 1'b1;
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          wcnt_nx  = 2'd0;
        end
      endcase
    end
  end

  // Branch condition from the compare flags
  always_comb begin
    case (id_brop)
      6'd6:    cond = cmp_zero;
      6'd7:    cond = ~cmp_zero;
      6'd33:   cond = cmp_gtzero;
      6'd34:   cond = cmp_gezero;
      6'd35:   cond = cmp_ltzero;
      6'd36:   cond = cmp_lezero;
      default: cond = 1'b0;
    endcase
    taken     = resolve & cond;
    flush_if  = taken;
    cmp_ctrl  = resolve ? id_brop : 6'd0;
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= 2'd0;
      br_cnt    <= '0;
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (resolve && (br_cnt != CNT_MAX))
        br_cnt <= br_cnt + CNT_ONE;
      if (taken && (taken_cnt != CNT_MAX))
        taken_cnt <= taken_cnt + CNT_ONE;
      if (stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [5:0]       id_brop;
  logic [4:0]       id_rs, id_rt;
  logic             ex_regwrite, ex_memread;
  logic [4:0]       ex_rd;
  logic             mem_memread;
  logic [4:0]       mem_rd;
  logic [5:0]       cmp_ctrl;
  logic             cmp_zero, cmp_gtzero, cmp_gezero, cmp_ltzero, cmp_lezero;
  logic             stall, taken, flush_if, illegal;
  logic [CNT_W-1:0] br_cnt, taken_cnt, stall_cnt;
  logic             dbg_state;

  int errors = 0;
  int checks = 0;
  int exp_br = 0, exp_tk = 0, exp_st = 0;
  logic [CNT_W-1:0] exp_q[$];

  branch_resolve_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_brop(id_brop),
    .id_rs(id_rs), .id_rt(id_rt), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_memread(mem_memread),
    .mem_rd(mem_rd), .cmp_ctrl(cmp_ctrl), .cmp_zero(cmp_zero),
    .cmp_gtzero(cmp_gtzero), .cmp_gezero(cmp_gezero),
    .cmp_ltzero(cmp_ltzero), .cmp_lezero(cmp_lezero), .stall(stall),
    .taken(taken), .flush_if(flush_if), .illegal(illegal),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; combinational outputs are sampled 1 ns later.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_valid = 0; id_brop = 0; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_memread = 0; mem_rd = 0;
    cmp_zero = 0; cmp_gtzero = 0; cmp_gezero = 0; cmp_ltzero = 0; cmp_lezero = 0;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, ".br"},    32'(br_cnt),    32'(exp_br));
    check({tag, ".taken"}, 32'(taken_cnt), 32'(exp_tk));
    check({tag, ".stall"}, 32'(stall_cnt), 32'(exp_st));
  endtask

  task automatic check_ctl(input string tag, input int e_stall, input int e_cmp,
                           input int e_taken, input int e_ill);
    check({tag, ".stall"},    32'(stall),    32'(e_stall));
    check({tag, ".cmp_ctrl"}, 32'(cmp_ctrl), 32'(e_cmp));
    check({tag, ".taken"},    32'(taken),    32'(e_taken));
    check({tag, ".flush_if"}, 32'(flush_if), 32'(e_taken));
    check({tag, ".illegal"},  32'(illegal),  32'(e_ill));
  endtask

  initial begin
    // reset with a live branch on the inputs: outputs must still be quiet
    quiet();
    reset = 1;
    id_valid = 1; id_brop = 6'd6; cmp_zero = 1;
    tick();
    settle();
    check_ctl("rst", 0, 0, 0, 0);
    tick();
    check_cnts("rst");
    check("rst.state", 32'(dbg_state), 0);
    reset = 0;
    quiet();
    tick();

    // beq, no hazard, taken
    id_valid = 1; id_brop = 6'd6; id_rs = 3; id_rt = 4; cmp_zero = 1;
    settle();
    check_ctl("beq", 0, 6, 1, 0);
    tick();
    exp_br = 1; exp_tk = 1;
    check_cnts("beq");

    // bgtz behind a load in EX: two stalls, then a resolve
    quiet();
    id_valid = 1; id_brop = 6'd33; id_rs = 5; ex_memread = 1; ex_regwrite = 1;
    ex_rd = 5; cmp_gtzero = 1;
    settle();
    check_ctl("bgtz.s1", 1, 0, 0, 0);
    tick();
    check("bgtz.state", 32'(dbg_state), 1);
    settle();
    check_ctl("bgtz.s2", 1, 0, 0, 0);
    tick();
    settle();
    check_ctl("bgtz.res", 0, 33, 1, 0);
    tick();
    exp_br = 2; exp_tk = 2; exp_st = 2;
    check_cnts("bgtz");

    // bne: EX ALU writer on rt and MEM load on rs -> one stall; cmp_zero=1 -> not taken
    quiet();
    id_valid = 1; id_brop = 6'd7; id_rs = 2; id_rt = 7;
    ex_regwrite = 1; ex_rd = 7; mem_memread = 1; mem_rd = 2; cmp_zero = 1;
    settle();
    check_ctl("bne.s1", 1, 0, 0, 0);
    tick();
    settle();
    check_ctl("bne.res", 0, 7, 0, 0);
    tick();
    exp_br = 3; exp_st = 3;
    check_cnts("bne");

    // bltz back to back after a resolve; rs=0 never hazards
    quiet();
    id_valid = 1; id_brop = 6'd35; id_rs = 0; ex_regwrite = 1; ex_rd = 0;
    cmp_ltzero = 1;
    settle();
    check_ctl("bltz", 0, 35, 1, 0);
    tick();
    exp_br = 4; exp_tk = 3;
    check_cnts("bltz");

    // illegal opcode
    quiet();
    id_valid = 1; id_brop = 6'd12; cmp_zero = 1;
    settle();
    check_ctl("ill", 0, 0, 0, 1);
    tick();
    check_cnts("ill");
    quiet();
    settle();
    check("ill.drop", 32'(illegal), 0);
    tick();

    // id_valid drops during a stall: the branch is abandoned
    id_valid = 1; id_brop = 6'd34; id_rs = 5; ex_memread = 1; ex_rd = 5;
    cmp_gezero = 1;
    settle();
    check_ctl("drop.s1", 1, 0, 0, 0);
    tick();
    id_valid = 0;
    settle();
    check_ctl("drop.s2", 0, 0, 0, 0);
    tick();
    exp_st = 4;
    check_cnts("drop");
    check("drop.state", 32'(dbg_state), 0);

    // reset during a stall
    id_valid = 1;
    settle();
    check("mid.s1", 32'(stall), 1);
    tick();
    reset = 1;
    id_brop = 6'd12;
    settle();
    check_ctl("mid.rst", 0, 0, 0, 0);
    tick();
    reset = 0;
    quiet();
    exp_br = 0; exp_tk = 0; exp_st = 0;
    check_cnts("mid");
    settle();
    check("mid.post_stall", 32'(stall), 0);
    check("mid.state", 32'(dbg_state), 0);
    tick();

    // saturation: 2^CNT_W+3 taken beqs in a row
    id_valid = 1; id_brop = 6'd6; id_rs = 1; id_rt = 2; cmp_zero = 1;
    for (int i = 1; i <= CMAX + 4; i++) begin
      exp_q.push_back((i > CMAX) ? CNT_W'(CMAX) : CNT_W'(i));
      tick();
      check("sat.br_step", 32'(br_cnt), 32'(exp_q.pop_front()));
    end
    exp_br = CMAX; exp_tk = CMAX;
    check_cnts("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
